ghost_collision_ctrl: RTL and testbench
=======================================

Name: ghost_collision_ctrl

Overview:
Downstream consumer of the ghost and ball position outputs. Once per frame it checks Pac-Man/ghost overlap, debounces hits, and runs the life/death/game-over state machine. It drives Over back into the ghost, and drives Respawn to re-seed actor start positions. Freeze halts motion logic during death and game-over.

Parameters:
HIT_DIST, 10'd12, overlap threshold in pixels, applied per axis (strict less-than)
HIT_FRAMES, 3'd2, consecutive overlapping frames required to register a hit (1..7)
DEATH_FRAMES, 8'd60, frames spent in DYING before respawn or game over (1..255)
INIT_LIVES, 2'd3, lives loaded at reset and at game start (1..3)

Ports:
frame_clk  in   1   frame clock; all state advances on its rising edge
Reset      in   1   asynchronous, active-high reset
Start      in   1   start/restart request, sampled on frame_clk
BallX      in   10  Pac-Man centre X
BallY      in   10  Pac-Man centre Y
GhostX     in   10  ghost centre X
GhostY     in   10  ghost centre Y
Over       out  1   game over, registered
Freeze     out  1   motion hold, registered
Respawn    out  1   one-frame pulse that re-seeds actor start positions, registered
Lives      out  2   remaining lives, registered
State      out  3   current FSM state encoding, for debug and HUD use

Behaviour:
- Clocking and reset: one clock, frame_clk; reset is asynchronous and active-high, port Reset.
- Reset values: State=IDLE, Lives=INIT_LIVES, Over=0, Freeze=1, Respawn=0, hit_cnt=0, death_cnt=0.
- Overlap term (combinational from the current inputs):
  - dx = |BallX-GhostX| and dy = |BallY-GhostY|, computed as unsigned 10-bit subtraction of larger minus smaller; no wrap.
  - overlap = (dx < HIT_DIST) && (dy < HIT_DIST).
- State encodings: IDLE=0, PLAY=1, DYING=2, OVER=3.
- IDLE:
  - Freeze=1, Over=0.
  - Start=1 -> PLAY; Respawn=1 for the following frame; Lives=INIT_LIVES.
- PLAY:
  - Freeze=0.
  - Each edge: overlap -> hit_cnt increments, saturating at HIT_FRAMES; no overlap -> hit_cnt=0.
  - An edge where overlap=1 and hit_cnt==HIT_FRAMES-1 -> DYING. On that same edge Lives decrements by 1, hit_cnt=0 and death_cnt=0.
  - HIT_FRAMES=1 means a single overlapping frame kills.
- DYING:
  - Freeze=1; death_cnt increments each edge.
  - When death_cnt==DEATH_FRAMES-1:
    - Lives==0 -> OVER.
    - Otherwise -> PLAY with a one-frame Respawn pulse.
  - Overlap is ignored while in DYING.
- OVER:
  - Over=1, Freeze=1.
  - Start=1 -> PLAY, Lives=INIT_LIVES, one-frame Respawn pulse, Over clears on that same edge.
- Start is ignored in PLAY and DYING.
- Respawn: high exactly one frame, namely the frame after the transition edge into PLAY. It is never high in two consecutive frames.
- Lives never underflows; a decrement happens only on PLAY->DYING, where Lives>=1 is guaranteed.
- Latency:
  - Overlap to DYING is HIT_FRAMES edges.
  - DYING entry to PLAY/OVER is DEATH_FRAMES edges.
- Reset mid-operation, in any state, returns immediately to the reset values; any pending Respawn pulse is dropped.
- Outputs are glitch-free registers except State, which is a direct copy of the state register.

Test Plan:
- Reset, then Start=1 for one frame -> State IDLE->PLAY; Respawn=1 for exactly one frame; Lives=3; Freeze=0.
- PLAY with Ball=(100,100), Ghost=(111,100) held for 2 frames -> DYING on the 2nd edge, Lives=2. Ghost=(112,100) (dx=12) held for 10 frames -> no hit.
- Overlap for 1 frame, gap of 1 frame, overlap for 1 frame (HIT_FRAMES=2) -> stays in PLAY, hit_cnt returns to 0.
- From DYING with Lives=2 -> exactly 60 frames later State=PLAY, Respawn pulses, Freeze drops. Inputs overlapping during DYING -> no extra decrement.
- Three hits -> Lives 3->2->1->0; after the 3rd DYING, State=OVER and Over=1. Start=1 -> PLAY, Lives=3, Over=0, Respawn pulse.
- Assert Reset at death_cnt=30 -> outputs asynchronously return to reset values (Lives=3, Freeze=1, Over=0, State=IDLE) before the next frame_clk edge.

Source files
------------

// File: rtl/ghost_collision_ctrl.sv
// Frame-rate Pac-Man/ghost collision controller: overlap detection, hit debounce,
// and the life/death/game-over state machine that drives Over, Freeze and Respawn.
module ghost_collision_ctrl #(
  parameter logic [9:0] HIT_DIST     = 10'd12,
  parameter logic [2:0] HIT_FRAMES   = 3'd2,
  parameter logic [7:0] DEATH_FRAMES = 8'd60,
  parameter logic [1:0] INIT_LIVES   = 2'd3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] GhostX,
  input  logic [9:0] GhostY,
  output logic       Over,
  output logic       Freeze,
  output logic       Respawn,
  output logic [1:0] Lives,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DYING = 3'd2,
    OVER  = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] hitCnt_q, hitCnt_d;
  logic [7:0] deathCnt_q, deathCnt_d;
  logic       over_q, over_d;
  logic       freeze_q, freeze_d;
  logic       respawn_q, respawn_d;

  logic [9:0] dx, dy;
  logic       overlap;

  // Larger-minus-smaller keeps the distance from wrapping near the screen edges.
  always_comb begin
    dx      = (BallX >= GhostX) ? (BallX - GhostX) : (GhostX - BallX);
    dy      = (BallY >= GhostY) ? (BallY - GhostY) : (GhostY - BallY);
    overlap = (dx < HIT_DIST) && (dy < HIT_DIST);
  end

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    hitCnt_d   = hitCnt_q;
    deathCnt_d = deathCnt_q;
    respawn_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (Start) begin
          state_d    = PLAY;
          lives_d    = INIT_LIVES;
          hitCnt_d   = 3'd0;
          deathCnt_d = 8'd0;
          respawn_d  = 1'b1;
        end
      end
      PLAY: begin
        if (!overlap) begin
          hitCnt_d = 3'd0;
        end else if (hitCnt_q == HIT_FRAMES - 3'd1) begin
          state_d    = DYING;
          lives_d    = lives_q - 2'd1;
          hitCnt_d   = 3'd0;
          deathCnt_d = 8'd0;
        end else if (hitCnt_q < HIT_FRAMES) begin
          hitCnt_d = hitCnt_q + 3'd1;
        end
      end
      DYING: begin
        if (deathCnt_q == DEATH_FRAMES - 8'd1) begin
          deathCnt_d = 8'd0;
          if (lives_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d   = PLAY;
            respawn_d = 1'b1;
          end
        end else begin
          deathCnt_d = deathCnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered flags follow the state being entered so they align with State.
    freeze_d = (state_d != PLAY);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      lives_q    <= INIT_LIVES;
      hitCnt_q   <= 3'd0;
      deathCnt_q <= 8'd0;
      over_q     <= 1'b0;
      freeze_q   <= 1'b1;
      respawn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      hitCnt_q   <= hitCnt_d;
      deathCnt_q <= deathCnt_d;
      over_q     <= over_d;
      freeze_q   <= freeze_d;
      respawn_q  <= respawn_d;
    end
  end

  assign Over    = over_q;
  assign Freeze  = freeze_q;
  assign Respawn = respawn_q;
  assign Lives   = lives_q;
  assign State   = state_q;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Directed bench for ghost_collision_ctrl: start, hit debounce, death timing,
// game over and restart, and asynchronous reset in the middle of a death.
module tb_ghost_collision_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [9:0] BallX, BallY, GhostX, GhostY;
  logic       Over, Freeze, Respawn;
  logic [1:0] Lives;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_DYING = 2;
  localparam int S_OVER  = 3;

  ghost_collision_ctrl dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .Start    (Start),
    .BallX    (BallX),
    .BallY    (BallY),
    .GhostX   (GhostX),
    .GhostY   (GhostY),
    .Over     (Over),
    .Freeze   (Freeze),
    .Respawn  (Respawn),
    .Lives    (Lives),
    .State    (State)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives the inputs, then advances n frame edges and returns on the falling edge.
  task automatic applyStimulus(input int bx, input int by, input int gx, input int gy,
                               input logic st, input int n);
    BallX  = 10'(bx);
    BallY  = 10'(by);
    GhostX = 10'(gx);
    GhostY = 10'(gy);
    Start  = st;
    repeat (n) @(negedge frame_clk);
    Start = 1'b0;
  endtask

  task automatic checkAll(input string tag, input int st, input int lv, input int fr,
                          input int ov, input int rs);
    checkOutput({tag, ".State"}, int'(State), st);
    checkOutput({tag, ".Lives"}, int'(Lives), lv);
    checkOutput({tag, ".Freeze"}, int'(Freeze), fr);
    checkOutput({tag, ".Over"}, int'(Over), ov);
    checkOutput({tag, ".Respawn"}, int'(Respawn), rs);
  endtask

  // Two overlapping frames from PLAY with hit_cnt at zero produce a hit.
  task automatic doHit(input string tag, input int livesAfter);
    applyStimulus(100, 100, 111, 100, 1'b0, 1);
    checkOutput({tag, ".firstOverlap"}, int'(State), S_PLAY);
    applyStimulus(100, 100, 111, 100, 1'b0, 1);
    checkAll({tag, ".hit"}, S_DYING, livesAfter, 1, 0, 0);
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(100, 100, 300, 300, 1'b0, 0);
    repeat (2) @(negedge frame_clk);
    checkAll("reset", S_IDLE, 3, 1, 0, 0);
    Reset = 1'b0;

    applyStimulus(100, 100, 300, 300, 1'b0, 2);
    checkAll("idleNoStart", S_IDLE, 3, 1, 0, 0);

    applyStimulus(100, 100, 300, 300, 1'b1, 1);
    checkAll("start", S_PLAY, 3, 0, 0, 1);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkAll("startPulseEnd", S_PLAY, 3, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(100, 100, 112, 100, 1'b0, 1);
      checkOutput("dx12NoHit", int'(State), S_PLAY);
    end
    applyStimulus(100, 100, 100, 112, 1'b0, 3);
    checkOutput("dy12NoHit", int'(State), S_PLAY);
    applyStimulus(5, 100, 1020, 100, 1'b0, 3);
    checkOutput("farNoWrap", int'(State), S_PLAY);
    applyStimulus(100, 100, 111, 89, 1'b0, 1);
    checkOutput("diagFirst", int'(State), S_PLAY);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkOutput("gapAfterDiag", int'(State), S_PLAY);
    applyStimulus(100, 100, 111, 100, 1'b0, 1);
    checkOutput("overlapAfterGap", int'(State), S_PLAY);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkAll("debounceHeld", S_PLAY, 3, 0, 0, 0);

    doHit("hit1", 2);
    applyStimulus(100, 100, 111, 100, 1'b1, 59);
    checkAll("dying59", S_DYING, 2, 1, 0, 0);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkAll("respawn1", S_PLAY, 2, 0, 0, 1);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkOutput("respawn1End", int'(Respawn), 0);

    doHit("hit2", 1);
    applyStimulus(100, 100, 300, 300, 1'b0, 60);
    checkAll("respawn2", S_PLAY, 1, 0, 0, 1);

    doHit("hit3", 0);
    applyStimulus(100, 100, 111, 100, 1'b0, 59);
    checkOutput("dying3Hold", int'(State), S_DYING);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkAll("gameOver", S_OVER, 0, 1, 1, 0);
    applyStimulus(100, 100, 300, 300, 1'b0, 3);
    checkAll("overHold", S_OVER, 0, 1, 1, 0);
    applyStimulus(100, 100, 300, 300, 1'b1, 1);
    checkAll("restart", S_PLAY, 3, 0, 0, 1);
    applyStimulus(100, 100, 300, 300, 1'b0, 1);
    checkOutput("restartPulseEnd", int'(Respawn), 0);

    doHit("hit4", 2);
    applyStimulus(100, 100, 300, 300, 1'b0, 30);
    checkOutput("midDeath", int'(State), S_DYING);
    #2;
    Reset = 1'b1;
    #1;
    checkAll("asyncReset", S_IDLE, 3, 1, 0, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    applyStimulus(100, 100, 300, 300, 1'b0, 2);
    checkAll("afterReset", S_IDLE, 3, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
